// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_SB_TICKS   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level; both stages reset to 1 (UART idle level).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q sample together, giving two real stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, oversampled by an external tick.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int SB_TICKS   = DEFAULT_SB_TICKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_parity_err
);

  // The tick counter must also reach SB_TICKS-1 when longer stop periods are configured.
  localparam int TICK_W = $clog2(OVERSAMPLE > SB_TICKS ? OVERSAMPLE : SB_TICKS);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_TICK = TICK_W'(SB_TICKS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rxs;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_rx),
    .q   (rxs)
  );

  uart_state_e          state, state_n;
  logic [TICK_W-1:0]    tick_cnt, tick_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 armed, armed_n;
  logic                 done_n, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_bit_n;
  logic                 perr_n;
`endif

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    data_n     = o_data;
    armed_n    = armed;
    done_n     = 1'b0;
    ferr_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n  = par_bit;
    perr_n     = 1'b0;
`endif

    unique case (state)
      ST_IDLE: begin
        if (rxs) begin
          armed_n = 1'b1;
        end else if (armed) begin
          state_n    = ST_START;
          tick_cnt_n = '0;
        end
      end

      ST_START: begin
        if (i_tick) begin
          if (tick_cnt == MID_TICK) begin
            // A line that is high again at mid start bit was a glitch.
            if (!rxs) begin
              state_n    = ST_DATA;
              tick_cnt_n = '0;
              bit_cnt_n  = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (i_tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt_n = '0;
            shreg_n    = {rxs, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (i_tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt_n = '0;
            par_bit_n  = rxs;
            state_n    = ST_STOP;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
`endif

      ST_STOP: begin
        if (i_tick) begin
          if (tick_cnt == STOP_TICK) begin
            state_n = ST_IDLE;
            // A low stop bit disarms start detection until the line is seen idle.
            if (!rxs) begin
              ferr_n  = 1'b1;
              armed_n = 1'b0;
`ifdef UART_RX_PARITY_EN
            end else if (^{shreg, par_bit}) begin
              perr_n = 1'b1;
`endif
            end else begin
              data_n = shreg;
              done_n = 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      armed       <= 1'b1;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      armed       <= armed_n;
      o_data      <= data_n;
      o_rx_done   <= done_n;
      o_frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bit      <= par_bit_n;
      o_parity_err <= perr_n;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, glitch/reset sequences, random frames.
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = TICK_DIV * OVS;
  localparam int N_VEC    = 10;
  localparam int N_RAND   = 20;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum int {EV_DONE = 0, EV_FERR = 1, EV_PERR = 2} ev_kind_e;

  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
  } event_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         flip;
    int         hold_low;
    int         gap;
    ev_kind_e   exp_kind;
    logic [7:0] exp_held;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_parity_err;

  int         n_checks = 0;
  int         n_errors = 0;
  event_t     obs[$];
  logic [7:0] last_good;
  vec_t       vecs[N_VEC];

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_rx_done    (o_rx_done),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err)
  );

  always #10 clk = ~clk;

  initial begin
    i_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Record every output pulse; at most one may be high in a cycle.
  always @(negedge clk) begin
    if (rst) begin
      int n;
      n = int'(o_rx_done) + int'(o_frame_err) + int'(o_parity_err);
      if (n != 0) begin
        check("one_pulse_per_cycle", n, 1);
        if (o_rx_done)        obs.push_back('{EV_DONE, o_data});
        else if (o_frame_err) obs.push_back('{EV_FERR, o_data});
        else                  obs.push_back('{EV_PERR, o_data});
      end
    end
  end

  task automatic drive_bit(input logic b, input int cycles);
    i_rx = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(v.data[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    drive_bit((^v.data) ^ v.flip, BIT_CLKS);
`endif
    drive_bit(v.stop, BIT_CLKS);
    if (v.hold_low > 0) drive_bit(1'b0, v.hold_low * BIT_CLKS);
    drive_bit(1'b1, v.gap * BIT_CLKS);
  endtask

  // Reference: stop bit decides framing, then (with parity) even parity of data+parity bit.
  function automatic ev_kind_e model_kind(input vec_t v);
    if (!v.stop)           return EV_FERR;
    if (PAR_EN && v.flip)  return EV_PERR;
    return EV_DONE;
  endfunction

  task automatic expect_event(input string tag, input ev_kind_e kind, input logic [7:0] data);
    event_t e;
    check({tag, "_event_seen"}, obs.size() > 0, 1'b1);
    if (obs.size() > 0) begin
      e = obs.pop_front();
      check({tag, "_kind"}, int'(e.kind), int'(kind));
      if (kind == EV_DONE) check({tag, "_data"}, e.data, data);
    end
    check({tag, "_no_extra"}, obs.size(), 0);
    obs.delete();
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    ev_kind_e k;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 0,  1, EV_DONE, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 20, 1, EV_FERR, 8'hA5};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 0,  1, EV_DONE, 8'h01};
    vecs[3] = '{8'h03, 1'b1, 1'b0, 0,  0, EV_DONE, 8'h03};
    vecs[4] = '{8'h05, 1'b1, 1'b0, 0,  0, EV_DONE, 8'h05};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 0,  1, EV_DONE, 8'h00};
    if (PAR_EN) vecs[6] = '{8'h81, 1'b1, 1'b1, 0, 1, EV_PERR, 8'h00};
    else        vecs[6] = '{8'h81, 1'b1, 1'b1, 0, 1, EV_DONE, 8'h81};
    vecs[7] = '{8'h81, 1'b1, 1'b0, 0,  1, EV_DONE, 8'h81};
    vecs[8] = '{8'hFF, 1'b1, 1'b0, 0,  1, EV_DONE, 8'hFF};
    vecs[9] = '{8'hC3, 1'b0, 1'b0, 0,  1, EV_FERR, 8'hFF};

    rst  = 1'b0;
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",   o_data, 8'h00);
    check("reset_done",   o_rx_done, 1'b0);
    check("reset_ferr",   o_frame_err, 1'b0);
    check("reset_perr",   o_parity_err, 1'b0);
    rst = 1'b1;
    last_good = 8'h00;
    drive_bit(1'b1, BIT_CLKS);

    for (int i = 0; i < N_VEC; i++) begin
      send_frame(vecs[i]);
      expect_event($sformatf("vec%0d", i), vecs[i].exp_kind, vecs[i].data);
      check($sformatf("vec%0d_held", i), o_data, vecs[i].exp_held);
      last_good = vecs[i].exp_held;
    end

    // Short low pulse: false start, nothing reported, next frame still received.
    drive_bit(1'b0, 4 * TICK_DIV);
    drive_bit(1'b1, 2 * BIT_CLKS);
    check("glitch_no_event", obs.size(), 0);
    check("glitch_held", o_data, last_good);
    v = '{8'h5A, 1'b1, 1'b0, 0, 1, EV_DONE, 8'h5A};
    send_frame(v);
    expect_event("after_glitch", EV_DONE, 8'h5A);
    last_good = 8'h5A;

    // Reset in the middle of data bit 4 of 0x7E.
    v.data = 8'h7E;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(v.data[i], BIT_CLKS);
    drive_bit(v.data[4], BIT_CLKS / 2);
    rst = 1'b0;
    #1;
    check("midreset_data", o_data, 8'h00);
    check("midreset_pulses", {o_rx_done, o_frame_err, o_parity_err}, 3'b000);
    i_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    last_good = 8'h00;
    drive_bit(1'b1, BIT_CLKS);
    check("midreset_no_event", obs.size(), 0);
    send_frame(v);
    expect_event("after_reset", EV_DONE, 8'h7E);
    last_good = 8'h7E;
    check("after_reset_held", o_data, last_good);

    for (int i = 0; i < N_RAND; i++) begin
      v.data     = 8'($urandom);
      v.stop     = ($urandom_range(7) != 0);
      v.flip     = ($urandom_range(3) == 0);
      v.hold_low = v.stop ? 0 : int'($urandom_range(3));
      v.gap      = v.stop ? int'($urandom_range(2)) : int'($urandom_range(2, 1));
      k = model_kind(v);
      if (k == EV_DONE) last_good = v.data;
      send_frame(v);
      expect_event($sformatf("rand%0d", i), k, v.data);
      check($sformatf("rand%0d_held", i), o_data, last_good);
    end

    repeat (2 * BIT_CLKS) @(negedge clk);
    check("final_no_event", obs.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
